// File: rtl/dm_stage_pkg.sv
// Data-memory access encodings and helper masks, shared by the memory stage
// and the ID-stage decoder.
package dm_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SB   = 4'd8
  } mem_op_e;

  // One bit per mem_op code; undefined codes read as neither load nor store.
  localparam logic [15:0] IS_LOAD  = 16'b0000_0000_0011_1110;
  localparam logic [15:0] IS_STORE = 16'b0000_0001_1100_0000;

endpackage

// File: rtl/dm_stage_if.sv
// Bundle between the MEM-stage control path and the data-memory stage.
interface dm_stage_if;

  logic        valid;
  logic [3:0]  mem_op;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic [4:0]  wa_in;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        misalign;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fault_pc;

  modport master (
    output valid, mem_op, alu_result, store_data, pc_in, instr_in, wa_in,
    input  pc, instr, wa, wd, misalign, fault, fault_addr, fault_pc
  );

  modport slave (
    input  valid, mem_op, alu_result, store_data, pc_in, instr_in, wa_in,
    output pc, instr, wa, wd, misalign, fault, fault_addr, fault_pc
  );

endinterface

// File: rtl/dm_stage_ram.sv
// Word-wide data memory: asynchronous read, byte-enabled synchronous write,
// and a one-cycle synchronous clear of every word on reset.
module dm_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [DEPTH];

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i[ADDR_WIDTH-1:0]] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read sees the pre-edge contents, so read-during-write returns old data.
  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dm_stage.sv
// MIPS memory-access stage: lane select/extension, store byte enables,
// misalignment detection and sticky first-fault capture.
module dm_stage
  import dm_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic    clk,
  input  logic    reset,
  dm_stage_if.slave bus
);

  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic [31:0]           w_rdata;
  logic [31:0]           w_wdata;
  logic [3:0]            w_be;
  logic                  w_mis_raw;
  logic                  w_misalign;
  logic                  w_we;
  logic                  w_is_sw;
  logic                  w_is_sh;
  logic                  w_is_sb;
  logic [15:0]           w_half;
  logic [7:0]            w_byte;
  logic [31:0]           w_wd;

  logic                  r_fault;
  logic [31:0]           r_fault_addr;
  logic [31:0]           r_fault_pc;

  // Upper address bits are dropped so accesses wrap modulo memory size.
  assign w_word_idx = bus.alu_result[ADDR_WIDTH+1:2];

  always_comb begin
    w_mis_raw = 1'b0;
    case (bus.mem_op)
      MEM_LW, MEM_SW:          w_mis_raw = |bus.alu_result[1:0];
      MEM_LH, MEM_LHU, MEM_SH: w_mis_raw = bus.alu_result[0];
      default:                 w_mis_raw = 1'b0;
    endcase
  end

  assign w_misalign = bus.valid & w_mis_raw;
  assign w_we       = bus.valid & IS_STORE[bus.mem_op] & ~w_misalign;
  assign w_is_sw    = (bus.mem_op == MEM_SW);
  assign w_is_sh    = (bus.mem_op == MEM_SH);
  assign w_is_sb    = (bus.mem_op == MEM_SB);

  // Store data is replicated across lanes; byte enables pick the target.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_wdata[8*gi +: 8] = w_is_sw ? bus.store_data[8*gi +: 8] :
                                w_is_sh ? bus.store_data[8*(gi%2) +: 8] :
                                          bus.store_data[7:0];
    assign w_be[gi] = w_we & (w_is_sw |
                              (w_is_sh & (bus.alu_result[1] == 1'(gi / 2))) |
                              (w_is_sb & (bus.alu_result[1:0] == 2'(gi))));
  end

  dm_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_be    (w_be),
    .i_addr  (w_word_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_half = bus.alu_result[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_byte = w_rdata[7:0];
    case (bus.alu_result[1:0])
      2'd0:    w_byte = w_rdata[7:0];
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      default: w_byte = w_rdata[31:24];
    endcase
  end

  always_comb begin
    w_wd = bus.alu_result;
    if (!w_misalign && IS_LOAD[bus.mem_op]) begin
      case (bus.mem_op)
        MEM_LW:  w_wd = w_rdata;
        MEM_LH:  w_wd = {{16{w_half[15]}}, w_half};
        MEM_LHU: w_wd = {16'h0000, w_half};
        MEM_LB:  w_wd = {{24{w_byte[7]}}, w_byte};
        MEM_LBU: w_wd = {24'h000000, w_byte};
        default: w_wd = bus.alu_result;
      endcase
    end
  end

  // Only the first misaligned access since reset is recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_fault_pc   <= '0;
    end else if (w_misalign && !r_fault) begin
      r_fault      <= 1'b1;
      r_fault_addr <= bus.alu_result;
      r_fault_pc   <= bus.pc_in;
    end
  end

  assign bus.pc         = bus.pc_in;
  assign bus.instr      = bus.instr_in;
  assign bus.wa         = w_misalign ? 5'd0 : bus.wa_in;
  assign bus.wd         = w_wd;
  assign bus.misalign   = w_misalign;
  assign bus.fault      = r_fault;
  assign bus.fault_addr = r_fault_addr;
  assign bus.fault_pc   = r_fault_pc;

endmodule
